prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream stage of the 9-bit CPU top level.
- Accepts a program as a stream of 9-bit instruction words over a valid/ready handshake and writes them into the instruction memory, starting at address 0.
- Holds the CPU in reset while loading, then releases it and waits for `done`. It reports the program length, the run-cycle count and an overflow error.
- Replaces bench-side backdoor writes to the instruction memory core.

Parameters:
- IW, 9, instruction word width.
- AW, 8, instruction memory address width (depth 2^AW).
- START_CYCLES, 2, minimum cycles `start` stays high after the last write; legal range 1..15.
- CW, 16, run-cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_req  in  1  begin a new load; sampled only in IDLE, DONE and ERR.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  IW  instruction word.
- in_last  in  1  final word of the program.
- im_we  out  1  instruction memory write enable.
- im_addr  out  AW  instruction memory write address.
- im_wdata  out  IW  instruction memory write data.
- cpu_start  out  1  drives CPU `start`; high holds the CPU in reset.
- cpu_done  in  1  CPU `done`.
- busy  out  1  high in LOAD, START and RUN.
- run_done  out  1  high in DONE.
- err  out  1  high in ERR (overflow).
- prog_len  out  AW+1  words written by the most recent load.
- run_cycles  out  CW  cycles spent in RUN, saturating.

Behaviour:
- **Reset (rst_n=0 at a clock edge, any state, including mid-load or mid-run):**
  - State goes to IDLE.
  - cpu_start=1.
  - in_ready, im_we, busy, run_done and err are 0.
  - im_addr, prog_len and run_cycles are 0; the word counter is 0.
  - Memory contents are untouched.
- **IDLE:**
  - cpu_start=1.
  - load_req=1 -> LOAD; the word counter clears to 0.
- **LOAD:**
  - in_ready=1; cpu_start=1.
  - im_we = in_valid & in_ready, combinational, in the same cycle as the handshake.
  - im_addr = the word counter (registered); im_wdata = in_data passthrough.
  - Each accepted word increments the counter at the clock edge.
  - Accepted word with in_last=1 -> START. prog_len <= counter+1, so a 1-word program gives prog_len=1.
  - Overflow: accepted word at address 2^AW-1 with in_last=0 is still written, then -> ERR. prog_len <= 2^AW.
  - Accepted word at address 2^AW-1 with in_last=1 is legal -> START, prog_len=2^AW.
  - in_valid=0 stalls indefinitely; there is no timeout.
  - load_req is ignored while in LOAD.
- **START:**
  - in_ready=0; cpu_start=1 for exactly START_CYCLES cycles (down-counter), then -> RUN.
  - run_cycles clears to 0 on entry.
  - cpu_done is ignored, since the CPU is held in reset.
- **RUN:**
  - cpu_start=0.
  - run_cycles increments every cycle in RUN and saturates at 2^CW-1.
  - cpu_done=1 -> DONE; run_cycles freezes. The cycle in which cpu_done is sampled high is counted.
  - load_req is ignored.
- **DONE:**
  - run_done=1; cpu_start stays 0, so the CPU holds its final state for inspection.
  - load_req=1 -> LOAD: cpu_start rises on the next cycle; run_done and prog_len are held until the new load finishes.
- **ERR:**
  - err=1; cpu_start=1 (CPU never released).
  - load_req=1 -> LOAD, and err clears.
- **General rules:**
  - Simultaneous in_valid/in_last with a state change: only LOAD accepts words, so a word presented in any other state is not consumed.
  - All outputs except im_we and im_wdata are registered.
  - A handshake completes only when in_valid=1 and in_ready=1 at the same edge. in_data must hold while in_valid=1 and in_ready=0.

Test Plan:
- **Reset and idle:** hold rst_n=0 for 3 cycles with load_req=1 and in_valid=1 -> cpu_start=1, in_ready=0, im_we=0, prog_len=0, run_cycles=0, state IDLE.
- **Basic load and run:**
  - Stimulus: load_req, then 3 words 0x1AC, 0x0F3, 0x1FF back-to-back, last flagged.
  - Required: im_we pulses at addr 0,1,2 with those data, prog_len=3, cpu_start high 2 cycles after the last write then low.
  - Then drive cpu_done after 40 RUN cycles -> run_done=1, run_cycles=40.
- **Backpressure and gaps:** in_valid toggles 1,0,0,1,1 with 3 words -> exactly 3 writes at addr 0..2, none in gap cycles; in_data held stable across the gaps is not duplicated.
- **Overflow (AW=3):**
  - Stream 9 words with no in_last -> 8 writes (addr 0..7), err=1 after the 8th, prog_len=8, 9th word not accepted, cpu_start stays 1.
  - load_req -> err clears.
- **Boundary exact fit (AW=3):** 8 words, last on the 8th -> no err, prog_len=8, RUN entered.
- **Reset mid-run and reload:**
  - rst_n=0 during RUN at cycle 10 -> cpu_start=1 next edge, IDLE, run_cycles=0.
  - Load 1 word -> prog_len=1; cpu_done asserted during START is ignored; run_cycles counts from RUN entry.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader for the 9-bit CPU: streams instruction words into the
// instruction memory from address 0, holds the CPU in reset while loading,
// releases it, then measures the run until the CPU reports done.
module prog_loader #(
  parameter int IW           = 9,
  parameter int AW           = 8,
  parameter int START_CYCLES = 2,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          cpu_start,
  input  logic          cpu_done,
  output logic          busy,
  output logic          run_done,
  output logic          err,
  output logic [AW:0]   prog_len,
  output logic [CW-1:0] run_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [3:0]    START_LOAD = 4'(START_CYCLES - 1);
  localparam logic [CW-1:0] RUN_MAX    = {CW{1'b1}};
  localparam logic [AW-1:0] ADDR_MAX   = {AW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic [CW-1:0] run_cycles_q, run_cycles_d;
  logic [3:0]    start_cnt_q, start_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          cpu_start_q, cpu_start_d;
  logic          busy_q, busy_d;
  logic          run_done_q, run_done_d;
  logic          err_q, err_d;
  logic          accept;

  // Handshake: in_ready_q is only ever high in LOAD, so this is the word-accept strobe.
  assign accept = in_valid & in_ready_q;

  // Next-state, word counter, length capture and run-cycle measurement.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prog_len_d   = prog_len_q;
    run_cycles_d = run_cycles_q;
    start_cnt_d  = start_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (in_last) begin
            state_d      = S_START;
            prog_len_d   = {1'b0, cnt_q} + (AW+1)'(1);
            start_cnt_d  = START_LOAD;
            run_cycles_d = '0;
          end else if (cnt_q == ADDR_MAX) begin
            // Last slot written with more words to come: the program does not fit.
            state_d    = S_ERR;
            prog_len_d = {1'b0, cnt_q} + (AW+1)'(1);
          end
        end
      end
      S_START: begin
        if (start_cnt_q == 4'd0) state_d = S_RUN;
        else                     start_cnt_d = start_cnt_q - 4'd1;
      end
      S_RUN: begin
        if (run_cycles_q != RUN_MAX) run_cycles_d = run_cycles_q + 1'b1;
        if (cpu_done) state_d = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs derived from the state being entered.
  always_comb begin
    in_ready_d  = (state_d == S_LOAD);
    cpu_start_d = !((state_d == S_RUN) || (state_d == S_DONE));
    busy_d      = (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_RUN);
    // run_done survives a reload until that load finishes.
    run_done_d  = (state_d == S_DONE) || (run_done_q && (state_d == S_LOAD));
    err_d       = (state_d == S_ERR);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      prog_len_q   <= '0;
      run_cycles_q <= '0;
      start_cnt_q  <= '0;
      in_ready_q   <= 1'b0;
      cpu_start_q  <= 1'b1;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prog_len_q   <= prog_len_d;
      run_cycles_q <= run_cycles_d;
      start_cnt_q  <= start_cnt_d;
      in_ready_q   <= in_ready_d;
      cpu_start_q  <= cpu_start_d;
      busy_q       <= busy_d;
      run_done_q   <= run_done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign im_we      = accept;
  assign im_addr    = cnt_q;
  assign im_wdata   = in_data;
  assign cpu_start  = cpu_start_q;
  assign busy       = busy_q;
  assign run_done   = run_done_q;
  assign err        = err_q;
  assign prog_len   = prog_len_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as
// words are offered, and a negedge monitor checks every im_we pulse.
module tb_prog_loader;

  localparam int IW = 9;
  localparam int AW = 3;
  localparam int SC = 2;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic          cpu_start;
  logic          cpu_done;
  logic          busy;
  logic          run_done;
  logic          err;
  logic [AW:0]   prog_len;
  logic [CW-1:0] run_cycles;

  int checks = 0;
  int errors = 0;
  logic [AW+IW-1:0] sb_q[$];

  prog_loader #(.IW(IW), .AW(AW), .START_CYCLES(SC), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_start(cpu_start), .cpu_done(cpu_done),
    .busy(busy), .run_done(run_done), .err(err),
    .prog_len(prog_len), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int addr, input logic [IW-1:0] data);
    sb_q.push_back({AW'(addr), data});
  endtask

  task automatic put(input logic [IW-1:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
  endtask

  // Monitor: every memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", im_addr, im_wdata);
      end else begin
        logic [AW+IW-1:0] e;
        e = sb_q.pop_front();
        if ({im_addr, im_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   im_addr, im_wdata, e[AW+IW-1:IW], e[IW-1:0]);
        end
      end
    end
  end

  initial begin
    // Reset held with load_req and in_valid asserted
    rst_n = 1'b0; load_req = 1'b1; in_valid = 1'b1; in_data = 9'h055;
    in_last = 1'b0; cpu_done = 1'b0;
    repeat (3) tick();
    chk("rst_cpu_start", cpu_start, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_im_we", im_we, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1; load_req = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_cpu_start", cpu_start, 1);

    // Basic load of three words and a 40-cycle run
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("load_in_ready", in_ready, 1);
    chk("load_busy", busy, 1);
    push(0, 9'h1AC); put(9'h1AC, 1'b0);
    push(1, 9'h0F3); put(9'h0F3, 1'b0);
    push(2, 9'h1FF); put(9'h1FF, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("basic_prog_len", prog_len, 3);
    chk("start_in_ready", in_ready, 0);
    chk("start_cpu_start0", cpu_start, 1);
    tick();
    chk("start_cpu_start1", cpu_start, 1);
    tick();
    chk("run_cpu_start", cpu_start, 0);
    chk("run_entry_cycles", run_cycles, 0);
    repeat (39) tick();
    chk("run_cycles_39", run_cycles, 39);
    cpu_done = 1'b1; tick(); cpu_done = 1'b0;
    chk("done_run_done", run_done, 1);
    chk("done_run_cycles", run_cycles, 40);
    chk("done_busy", busy, 0);
    chk("done_cpu_start", cpu_start, 0);
    tick();
    chk("done_frozen", run_cycles, 40);

    // Reload from DONE with gaps in in_valid
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("reload_cpu_start", cpu_start, 1);
    chk("reload_run_done_held", run_done, 1);
    chk("reload_prog_len_held", prog_len, 3);
    push(0, 9'h0A5); put(9'h0A5, 1'b0);
    in_valid = 1'b0; in_data = 9'h15A;
    tick(); tick();
    push(1, 9'h15A); put(9'h15A, 1'b0);
    push(2, 9'h033); put(9'h033, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("gap_run_done_clr", run_done, 0);
    chk("gap_prog_len", prog_len, 3);
    tick(); tick();
    chk("gap_run_cpu_start", cpu_start, 0);
    repeat (69) tick();
    chk("run_saturate", run_cycles, 63);
    cpu_done = 1'b1; tick(); cpu_done = 1'b0;
    chk("sat_done", run_done, 1);
    chk("sat_cycles", run_cycles, 63);

    // Overflow: nine words offered, none flagged last
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(i, 9'h100 + 9'(i));
      put(9'h100 + 9'(i), 1'b0);
    end
    in_data = 9'h1EE;
    chk("ovf_err", err, 1);
    chk("ovf_prog_len", prog_len, 8);
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_im_we", im_we, 0);
    chk("ovf_cpu_start", cpu_start, 1);
    chk("ovf_busy", busy, 0);
    tick(); tick();
    chk("ovf_err_hold", err, 1);
    chk("ovf_cpu_start_hold", cpu_start, 1);
    in_valid = 1'b0;
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("ovf_err_clear", err, 0);
    chk("ovf_reload_busy", busy, 1);

    // Exact fit: eight words, last on the eighth
    for (int i = 0; i < 8; i++) begin
      push(i, 9'h080 + 9'(i));
      put(9'h080 + 9'(i), (i == 7));
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("fit_err", err, 0);
    chk("fit_prog_len", prog_len, 8);
    chk("fit_in_ready", in_ready, 0);
    chk("fit_busy", busy, 1);
    tick(); tick();
    chk("fit_run", cpu_start, 0);

    // Reset during RUN, then a one-word program
    repeat (9) tick();
    chk("mid_run_cycles", run_cycles, 9);
    rst_n = 1'b0; tick();
    chk("midrst_cpu_start", cpu_start, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_run_cycles", run_cycles, 0);
    chk("midrst_prog_len", prog_len, 0);
    rst_n = 1'b1; tick();
    load_req = 1'b1; tick(); load_req = 1'b0;
    push(0, 9'h1C3); put(9'h1C3, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("one_prog_len", prog_len, 1);
    cpu_done = 1'b1; tick();
    chk("start_done_ignored", run_done, 0);
    chk("start_busy", busy, 1);
    chk("start_cpu_start", cpu_start, 1);
    tick();
    cpu_done = 1'b0;
    chk("one_run_cpu_start", cpu_start, 0);
    chk("one_run_entry", run_cycles, 0);
    chk("one_run_not_done", run_done, 0);
    repeat (4) tick();
    cpu_done = 1'b1; tick(); cpu_done = 1'b0;
    chk("one_done", run_done, 1);
    chk("one_run_cycles", run_cycles, 5);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
